hex_scroll_display: RTL



---
 rtl/hex_scroll_display_if.sv | 28 ++
 rtl/hex_scroll_display.sv | 124 ++++++++++++
 2 files changed

// File: rtl/hex_scroll_display_if.sv
// Bus between the switch/KEY conditioning logic and the scrolling HEX display:
// message load/scroll controls in, segment drive and window offset out.
interface hex_scroll_display_if #(
    parameter int unsigned NUM_DISP = 6,
    parameter int unsigned MSG_LEN  = 8
);
    localparam int unsigned CHAR_W = 3;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned POS_W  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    logic [CHAR_W*MSG_LEN-1:0] msg;
    logic                      load;
    logic                      enable;
    logic                      dir;
    logic                      step;
    logic [SEG_W*NUM_DISP-1:0] hex;
    logic [POS_W-1:0]          pos;

    modport master (
        output msg, load, enable, dir, step,
        input  hex, pos
    );

    modport slave (
        input  msg, load, enable, dir, step,
        output hex, pos
    );
endinterface

// File: rtl/hex_scroll_display.sv
// Scrolls a NUM_DISP-wide window across a MSG_LEN-character message on the
// 7-segment displays, with auto-scroll tick, single step, pause and reload.
module hex_scroll_display #(
    parameter int unsigned NUM_DISP = 6,
    parameter int unsigned MSG_LEN  = 8,
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    hex_scroll_display_if.slave bus
);
    localparam int unsigned CHAR_W = 3;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned POS_W  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SUM_W  = POS_W + 4;

    localparam logic [CHAR_W-1:0] CHAR_BLANK = CHAR_W'(4);
    localparam logic [POS_W-1:0]  POS_LAST   = POS_W'(MSG_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TICK_DIV - 1);

    generate
        if (NUM_DISP < 1 || NUM_DISP > 8) begin : g_bad_num_disp
            $error("hex_scroll_display: NUM_DISP must be in 1..8");
        end
        if (MSG_LEN < 2 || MSG_LEN > 16) begin : g_bad_msg_len
            $error("hex_scroll_display: MSG_LEN must be in 2..16");
        end
        if (TICK_DIV < 2) begin : g_bad_tick_div
            $error("hex_scroll_display: TICK_DIV must be at least 2");
        end
    endgenerate

    // Character code to active-low segment pattern; codes 4..7 are blank.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [CHAR_W-1:0] c);
        logic [SEG_W-1:0] seg;
        case (c)
            CHAR_W'(0): seg = 7'h21;
            CHAR_W'(1): seg = 7'h06;
            CHAR_W'(2): seg = 7'h79;
            CHAR_W'(3): seg = 7'h40;
            default:    seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [CHAR_W-1:0]         buf_q [MSG_LEN];
    logic [POS_W-1:0]          offset_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [SEG_W*NUM_DISP-1:0] hex_q;

    logic                      tick;
    logic                      advance;
    logic [POS_W-1:0]          offset_step;
    logic [SUM_W-1:0]          win_sum;
    logic [POS_W-1:0]          win_idx;
    logic [SEG_W*NUM_DISP-1:0] hex_next;

    assign tick    = (cnt_q == CNT_LAST);
    // A tick and a step landing together still move the window only once.
    assign advance = (tick & bus.enable) | bus.step;

    // One position left or right, wrapping at both ends of the message.
    always_comb begin : offset_next
        offset_step = offset_q;
        if (bus.dir) begin
            offset_step = (offset_q == '0) ? POS_LAST : offset_q - POS_W'(1);
        end else begin
            offset_step = (offset_q == POS_LAST) ? '0 : offset_q + POS_W'(1);
        end
    end

    // Display k shows buffer[(offset + NUM_DISP-1-k) mod MSG_LEN]; leftmost is buffer[offset].
    always_comb begin : window_map
        hex_next = '1;
        win_sum  = '0;
        win_idx  = '0;
        for (int unsigned k = 0; k < NUM_DISP; k++) begin
            win_sum = SUM_W'(offset_q) + SUM_W'(NUM_DISP - 1 - k);
            win_idx = POS_W'(win_sum % SUM_W'(MSG_LEN));
            hex_next[SEG_W*k +: SEG_W] = seg_decode(buf_q[win_idx]);
        end
    end

    // Scroll tick divider; frozen while paused, restarted by a load.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (bus.load) begin
            cnt_q <= '0;
        end else if (bus.enable) begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Message buffer and window offset; load has priority over any advance.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MSG_LEN; i++) begin
                buf_q[i] <= CHAR_BLANK;
            end
            offset_q <= '0;
        end else if (bus.load) begin
            for (int unsigned i = 0; i < MSG_LEN; i++) begin
                buf_q[i] <= bus.msg[CHAR_W*i +: CHAR_W];
            end
            offset_q <= '0;
        end else if (advance) begin
            offset_q <= offset_step;
        end
    end

    // Segment drive is registered one cycle behind the offset.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hex_q <= '1;
        end else begin
            hex_q <= hex_next;
        end
    end

    assign bus.hex = hex_q;
    assign bus.pos = offset_q;
endmodule
